// File: rtl/airi5c_spram_scheduler.sv
// rtl/airi5c_spram_scheduler.sv - shares one single-port SRAM between the imem and dmem AHB-Lite ports
module airi5c_spram_scheduler #(
    parameter int         ADDR_WIDTH  = 16,
    parameter logic [1:0] REGION      = 2'b10,
    parameter int         MAX_DSTREAK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           imem_haddr,
    input  logic                  imem_hwrite,
    input  logic [2:0]            imem_hsize,
    input  logic [1:0]            imem_htrans,
    output logic [31:0]           imem_hrdata,
    output logic                  imem_hready,
    output logic                  imem_hresp,
    input  logic [31:0]           dmem_haddr,
    input  logic                  dmem_hwrite,
    input  logic [2:0]            dmem_hsize,
    input  logic [1:0]            dmem_htrans,
    input  logic [31:0]           dmem_hwdata,
    output logic [31:0]           dmem_hrdata,
    output logic                  dmem_hready,
    output logic                  dmem_hresp,
    output logic                  sram_en,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [3:0]            sram_we,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DONE = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } port_state_t;

    localparam logic [3:0] LP_MAX_DSTREAK = 4'(MAX_DSTREAK);

    port_state_t           r_i_state, r_d_state, w_i_next, w_d_next;
    logic [ADDR_WIDTH-1:0] r_i_addr;
    logic [ADDR_WIDTH+1:0] r_d_addr;
    logic                  r_d_write;
    logic [1:0]            r_d_size;
    logic [3:0]            r_streak;

    logic       w_i_ready, w_d_ready, w_i_capture, w_d_capture;
    logic       w_i_legal, w_d_legal, w_i_wait, w_d_wait;
    logic       w_i_issue, w_d_issue;
    logic [3:0] w_d_be;
    logic       w_unused;

    // Size/alignment legality shared by both ports; sizes above a word never reach SRAM.
    function automatic logic f_align_ok(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'd0:    f_align_ok = 1'b1;
            3'd1:    f_align_ok = ~a[0];
            3'd2:    f_align_ok = (a == 2'b00);
            default: f_align_ok = 1'b0;
        endcase
    endfunction

    assign w_i_legal   = f_align_ok(imem_hsize, imem_haddr[1:0]) && !imem_hwrite;
    assign w_d_legal   = f_align_ok(dmem_hsize, dmem_haddr[1:0]) && (dmem_haddr[31:30] == REGION);

    assign w_i_ready   = (r_i_state == S_IDLE) || (r_i_state == S_DONE) || (r_i_state == S_ERR2);
    assign w_d_ready   = (r_d_state == S_IDLE) || (r_d_state == S_DONE) || (r_d_state == S_ERR2);
    assign w_i_capture = imem_htrans[1] && w_i_ready;
    assign w_d_capture = dmem_htrans[1] && w_d_ready;

    assign w_i_wait    = (r_i_state == S_WAIT);
    assign w_d_wait    = (r_d_state == S_WAIT);

    // dmem wins conflicts until it has won MAX_DSTREAK in a row over a waiting imem.
    assign w_i_issue   = w_i_wait && (!w_d_wait || (r_streak == LP_MAX_DSTREAK));
    assign w_d_issue   = w_d_wait && !w_i_issue;

    assign imem_hready = w_i_ready;
    assign dmem_hready = w_d_ready;
    assign imem_hresp  = (r_i_state == S_ERR1) || (r_i_state == S_ERR2);
    assign dmem_hresp  = (r_d_state == S_ERR1) || (r_d_state == S_ERR2);
    assign imem_hrdata = sram_rdata;
    assign dmem_hrdata = sram_rdata;

    assign sram_en     = (w_i_issue || w_d_issue) && !reset;
    assign sram_addr   = w_i_issue ? r_i_addr : r_d_addr[ADDR_WIDTH+1:2];
    assign sram_we     = (w_d_issue && r_d_write && !reset) ? w_d_be : 4'b0000;
    assign sram_wdata  = dmem_hwdata;

    assign w_unused    = ^{imem_haddr[31:ADDR_WIDTH+2], imem_htrans[0], dmem_htrans[0],
                           dmem_haddr[29:ADDR_WIDTH+2]};

    // Byte lanes of the latched dmem write.
    always_comb begin
        w_d_be = 4'b1111;
        case (r_d_size)
            2'd0:    w_d_be = 4'b0001 << r_d_addr[1:0];
            2'd1:    w_d_be = 4'b0011 << {r_d_addr[1], 1'b0};
            default: w_d_be = 4'b1111;
        endcase
    end

    // imem port next state.
    always_comb begin
        w_i_next = r_i_state;
        case (r_i_state)
            S_IDLE, S_DONE, S_ERR2: w_i_next = w_i_capture ? (w_i_legal ? S_WAIT : S_ERR1) : S_IDLE;
            S_WAIT:                 w_i_next = w_i_issue ? S_DONE : S_WAIT;
            S_ERR1:                 w_i_next = S_ERR2;
            default:                w_i_next = S_IDLE;
        endcase
    end

    // dmem port next state.
    always_comb begin
        w_d_next = r_d_state;
        case (r_d_state)
            S_IDLE, S_DONE, S_ERR2: w_d_next = w_d_capture ? (w_d_legal ? S_WAIT : S_ERR1) : S_IDLE;
            S_WAIT:                 w_d_next = w_d_issue ? S_DONE : S_WAIT;
            S_ERR1:                 w_d_next = S_ERR2;
            default:                w_d_next = S_IDLE;
        endcase
    end

    // Port states and the imem starvation counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_i_state <= S_IDLE;
            r_d_state <= S_IDLE;
            r_streak  <= 4'd0;
        end else begin
            r_i_state <= w_i_next;
            r_d_state <= w_d_next;
            if (w_i_issue || !w_i_wait) begin
                r_streak <= 4'd0;
            end else if (w_d_issue && (r_streak != LP_MAX_DSTREAK)) begin
                r_streak <= r_streak + 4'd1;
            end
        end
    end

    // Address-phase capture; the latched request is held until the port is ready again.
    always_ff @(posedge clk) begin
        if (w_i_capture) begin
            r_i_addr <= imem_haddr[ADDR_WIDTH+1:2];
        end
        if (w_d_capture) begin
            r_d_addr  <= dmem_haddr[ADDR_WIDTH+1:0];
            r_d_write <= dmem_hwrite;
            r_d_size  <= dmem_hsize[1:0];
        end
    end

endmodule

// File: tb/tb_airi5c_spram_scheduler.sv
// tb/tb_airi5c_spram_scheduler.sv - randomized bench for airi5c_spram_scheduler against a transaction model
module tb_airi5c_spram_scheduler;

    localparam int MAXD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_haddr, dmem_haddr, dmem_hwdata;
    logic        imem_hwrite, dmem_hwrite;
    logic [2:0]  imem_hsize, dmem_hsize;
    logic [1:0]  imem_htrans, dmem_htrans;
    logic [31:0] imem_hrdata, dmem_hrdata;
    logic        imem_hready, imem_hresp, dmem_hready, dmem_hresp;
    logic        sram_en;
    logic [15:0] sram_addr;
    logic [3:0]  sram_we;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    airi5c_spram_scheduler #(.ADDR_WIDTH(16), .REGION(2'b10), .MAX_DSTREAK(MAXD)) dut (
        .clk(clk), .reset(reset),
        .imem_haddr(imem_haddr), .imem_hwrite(imem_hwrite), .imem_hsize(imem_hsize),
        .imem_htrans(imem_htrans), .imem_hrdata(imem_hrdata), .imem_hready(imem_hready),
        .imem_hresp(imem_hresp),
        .dmem_haddr(dmem_haddr), .dmem_hwrite(dmem_hwrite), .dmem_hsize(dmem_hsize),
        .dmem_htrans(dmem_htrans), .dmem_hwdata(dmem_hwdata), .dmem_hrdata(dmem_hrdata),
        .dmem_hready(dmem_hready), .dmem_hresp(dmem_hresp),
        .sram_en(sram_en), .sram_addr(sram_addr), .sram_we(sram_we),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A5A5A;
    endfunction

    // SRAM macro stand-in: 64 words, one-cycle read latency, byte writes.
    logic        mem_init;
    logic [31:0] sram_mem [0:63];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) sram_mem[i] <= init_val(i);
        end else if (sram_en) begin
            for (int b = 0; b < 4; b++)
                if (sram_we[b]) sram_mem[sram_addr[5:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
            sram_rdata <= sram_mem[sram_addr[5:0]];
        end
    end

    // Reference model: per port an outstanding request, a post-issue response cycle and an error countdown.
    logic [31:0] ref_mem [0:63];
    bit          m_pend [2];
    bit          m_done [2];
    bit          m_wr   [2];
    int          m_err  [2];
    logic [31:0] m_addr [2];
    logic [2:0]  m_size [2];
    logic [31:0] m_rd   [2];
    int          m_streak;
    bit          m_new_wr;
    logic [31:0] d_wdata;
    int          n_checks, n_errors;
    int          i_wait_run, i_wait_max, en_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input int p, input logic [31:0] a, input logic w, input logic [2:0] s);
        if (s > 3'd2) return 1'b0;
        if ((a % (32'd1 << s)) != 0) return 1'b0;
        if (p == 1 && a[31:30] != 2'b10) return 1'b0;
        if (p == 0 && w) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] lanes(input logic [31:0] a, input logic [2:0] s);
        int n  = 1 << s;
        int lo = int'(a[1:0]);
        int off = lo - (lo % n);
        return 4'(((1 << n) - 1) << off);
    endfunction

    // Compare this cycle's outputs with the model, then advance the model over the coming edge.
    task automatic model_step();
        bit          iss [2];
        logic [1:0]  t   [2];
        logic [31:0] a   [2];
        logic        w   [2];
        logic [2:0]  s   [2];
        logic        rdy_o [2];
        logic        rsp_o [2];
        logic [31:0] rd_o  [2];
        logic [3:0]  exp_we;
        int          idx;
        t[0] = imem_htrans; a[0] = imem_haddr; w[0] = imem_hwrite; s[0] = imem_hsize;
        t[1] = dmem_htrans; a[1] = dmem_haddr; w[1] = dmem_hwrite; s[1] = dmem_hsize;
        rdy_o[0] = imem_hready; rsp_o[0] = imem_hresp; rd_o[0] = imem_hrdata;
        rdy_o[1] = dmem_hready; rsp_o[1] = dmem_hresp; rd_o[1] = dmem_hrdata;

        iss[0] = m_pend[0] && (!m_pend[1] || m_streak == MAXD);
        iss[1] = m_pend[1] && !iss[0];

        for (int p = 0; p < 2; p++) begin
            check($sformatf("p%0d_hready", p), rdy_o[p], (!m_pend[p] && m_err[p] != 2));
            check($sformatf("p%0d_hresp", p), rsp_o[p], (m_err[p] != 0));
            if (m_done[p] && !m_wr[p]) check($sformatf("p%0d_hrdata", p), rd_o[p], m_rd[p]);
        end
        check("sram_en", sram_en, (iss[0] || iss[1]) && !reset);
        exp_we = (iss[1] && m_wr[1] && !reset) ? lanes(m_addr[1], m_size[1]) : 4'b0000;
        check("sram_we", sram_we, exp_we);
        if ((iss[0] || iss[1]) && !reset) begin
            check("sram_addr", sram_addr, (iss[0] ? m_addr[0] : m_addr[1]) >> 2 & 32'hFFFF);
            if (exp_we != 0) check("sram_wdata", sram_wdata, d_wdata);
        end

        if (!reset && !imem_hready && !imem_hresp) i_wait_run++;
        else i_wait_run = 0;
        if (i_wait_run > i_wait_max) i_wait_max = i_wait_run;
        if (sram_en) en_count++;

        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                m_pend[p] = 0; m_done[p] = 0; m_err[p] = 0;
            end
            m_streak = 0; m_new_wr = 0;
            return;
        end

        for (int p = 0; p < 2; p++) begin
            if (iss[p]) begin
                idx = int'(m_addr[p][7:2]);
                if (m_wr[p]) begin
                    for (int b = 0; b < 4; b++)
                        if (exp_we[b]) ref_mem[idx][8*b +: 8] = d_wdata[8*b +: 8];
                end else begin
                    m_rd[p] = ref_mem[idx];
                end
            end
        end

        if (iss[0] || !m_pend[0]) m_streak = 0;
        else if (iss[1] && m_streak < MAXD) m_streak++;

        m_new_wr = 0;
        for (int p = 0; p < 2; p++) begin
            if (!m_pend[p] && m_err[p] != 2 && t[p][1]) begin
                m_pend[p] = legal(p, a[p], w[p], s[p]);
                m_err[p]  = m_pend[p] ? 0 : 2;
                m_done[p] = 0;
                m_addr[p] = a[p]; m_wr[p] = w[p]; m_size[p] = s[p];
                if (p == 1 && m_pend[p] && w[p]) m_new_wr = 1;
            end else if (m_pend[p]) begin
                if (iss[p]) begin
                    m_pend[p] = 0;
                    m_done[p] = 1;
                end
            end else begin
                m_done[p] = 0;
                if (m_err[p] > 0) m_err[p]--;
            end
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        model_step();
    endtask

    task automatic req(input int p, input logic [31:0] a, input logic w, input logic [2:0] s);
        if (p == 0) begin
            imem_htrans = 2'b10; imem_haddr = a; imem_hwrite = w; imem_hsize = s;
        end else begin
            dmem_htrans = 2'b10; dmem_haddr = a; dmem_hwrite = w; dmem_hsize = s;
        end
    endtask

    task automatic idle_all();
        imem_htrans = 2'b00;
        dmem_htrans = 2'b00;
    endtask

    task automatic set_wdata(input logic [31:0] v);
        d_wdata = v;
        dmem_hwdata = v;
    endtask

    task automatic err_case(input string tag, input int p, input logic [31:0] a,
                            input logic w, input logic [2:0] s);
        drive_edge(); req(p, a, w, s); sample();
        drive_edge(); idle_all(); sample();
        check({tag, "_err1_hready"}, p ? dmem_hready : imem_hready, 1'b0);
        check({tag, "_err1_hresp"},  p ? dmem_hresp  : imem_hresp,  1'b1);
        check({tag, "_err1_en"}, sram_en, 1'b0);
        drive_edge(); sample();
        check({tag, "_err2_hready"}, p ? dmem_hready : imem_hready, 1'b1);
        check({tag, "_err2_hresp"},  p ? dmem_hresp  : imem_hresp,  1'b1);
        check({tag, "_err2_en"}, sram_en, 1'b0);
        drive_edge(); sample();
        check({tag, "_after_hresp"}, p ? dmem_hresp : imem_hresp, 1'b0);
    endtask

    task automatic rnd_req(input bit dm, output logic [31:0] a, output logic w, output logic [2:0] s);
        s = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        a = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 9) != 0) a = a & ~((32'd1 << s) - 32'd1);
        if (dm) a[31:30] = ($urandom_range(0, 19) == 0) ? 2'b01 : 2'b10;
        w = dm ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 29) == 0);
    endtask

    task automatic drive_random();
        logic [31:0] a;
        logic        w;
        logic [2:0]  s;
        reset = ($urandom_range(0, 199) == 0);
        if (imem_hready) begin
            rnd_req(1'b0, a, w, s);
            req(0, a, w, s);
            if ($urandom_range(0, 9) < 3) imem_htrans = 2'b00;
        end
        if (dmem_hready) begin
            rnd_req(1'b1, a, w, s);
            req(1, a, w, s);
            if ($urandom_range(0, 9) < 3) dmem_htrans = 2'b00;
        end
        if (m_new_wr) set_wdata($urandom);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        i_wait_run = 0; i_wait_max = 0; en_count = 0;
        m_streak = 0; m_new_wr = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        reset = 1'b1; mem_init = 1'b1;
        imem_haddr = 0; imem_hwrite = 0; imem_hsize = 3'd2; imem_htrans = 0;
        dmem_haddr = 0; dmem_hwrite = 0; dmem_hsize = 3'd2; dmem_htrans = 0;
        set_wdata(32'h0);

        repeat (2) @(posedge clk);
        #1; mem_init = 1'b0;
        sample();
        check("rst_imem_hready", imem_hready, 1'b1);
        check("rst_dmem_hready", dmem_hready, 1'b1);
        check("rst_hresp", {imem_hresp, dmem_hresp}, 2'b00);
        check("rst_sram_en", sram_en, 1'b0);
        check("rst_sram_we", sram_we, 4'h0);

        // Word write then imem read-back of the same word.
        drive_edge(); reset = 1'b0; req(1, 32'h80000010, 1'b1, 3'd2); sample();
        drive_edge(); idle_all(); set_wdata(32'hDEADBEEF); sample();
        check("wr_en", sram_en, 1'b1);
        check("wr_addr", sram_addr, 16'h0004);
        check("wr_we", sram_we, 4'hF);
        check("wr_wdata", sram_wdata, 32'hDEADBEEF);
        check("wr_wait_hready", dmem_hready, 1'b0);
        drive_edge(); sample();
        check("wr_done_hready", dmem_hready, 1'b1);
        drive_edge(); req(0, 32'h00000010, 1'b0, 3'd2); sample();
        drive_edge(); idle_all(); sample();
        check("ird_wait_hready", imem_hready, 1'b0);
        check("ird_en", sram_en, 1'b1);
        check("ird_addr", sram_addr, 16'h0004);
        check("ird_we", sram_we, 4'h0);
        drive_edge(); sample();
        check("ird_done_hready", imem_hready, 1'b1);
        check("ird_data", imem_hrdata, 32'hDEADBEEF);

        // Byte and halfword writes, then a word read of the merged result.
        drive_edge(); req(1, 32'h80000013, 1'b1, 3'd0); sample();
        drive_edge(); idle_all(); set_wdata(32'hAB000000); sample();
        check("byte_we", sram_we, 4'b1000);
        drive_edge(); req(1, 32'h80000012, 1'b1, 3'd1); sample();
        drive_edge(); idle_all(); set_wdata(32'h12340000); sample();
        check("half_we", sram_we, 4'b1100);
        drive_edge(); req(1, 32'h80000010, 1'b0, 3'd2); sample();
        drive_edge(); idle_all(); sample();
        drive_edge(); sample();
        check("merge_data", dmem_hrdata, 32'h1234BEEF);

        err_case("dm_region", 1, 32'h40000000, 1'b0, 3'd2);
        err_case("dm_misalign", 1, 32'h80000001, 1'b0, 3'd1);
        err_case("im_write", 0, 32'h00000020, 1'b1, 3'd2);
        err_case("dm_size3", 1, 32'h80000020, 1'b0, 3'd3);

        // Both ports streaming reads back to back.
        i_wait_max = 0; en_count = 0;
        for (int c = 0; c < 40; c++) begin
            drive_edge();
            if (imem_hready) req(0, 32'($urandom_range(0, 63)) << 2, 1'b0, 3'd2);
            if (dmem_hready) req(1, 32'h80000000 | (32'($urandom_range(0, 63)) << 2), 1'b0, 3'd2);
            sample();
        end
        check("stream_busy", en_count, 39);
        check("stream_imem_wait_bound", i_wait_max <= MAXD + 1, 1'b1);
        drive_edge(); idle_all(); sample();
        drive_edge(); sample();
        drive_edge(); sample();

        // Reset during a dmem write's wait cycle drops the write.
        drive_edge(); req(1, 32'h80000008, 1'b1, 3'd2); sample();
        drive_edge(); idle_all(); reset = 1'b1; set_wdata(32'hCAFEF00D); sample();
        check("rstw_we", sram_we, 4'h0);
        check("rstw_en", sram_en, 1'b0);
        drive_edge(); reset = 1'b0; sample();
        check("rstw_imem_hready", imem_hready, 1'b1);
        check("rstw_dmem_hready", dmem_hready, 1'b1);
        check("rstw_hresp", {imem_hresp, dmem_hresp}, 2'b00);
        drive_edge(); req(1, 32'h80000008, 1'b0, 3'd2); sample();
        drive_edge(); idle_all(); sample();
        drive_edge(); sample();
        check("rstw_nowrite", dmem_hrdata, init_val(2));

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            drive_edge();
            drive_random();
            sample();
        end
        drive_edge(); reset = 1'b0; idle_all(); sample();
        repeat (3) begin
            drive_edge(); sample();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/airi5c_spram_scheduler.md
Name: airi5c_spram_scheduler

Overview:
- Shares one single-port synchronous block RAM (1-cycle read latency, byte write enables) between the core's instruction port and data port.
- Both ports are HASTI/AHB-Lite slave ports.
- Arbitration policy:
  - dmem has fixed priority.
  - A starvation counter bounds imem wait time.
- Performs access checks (region, alignment, size, imem write) and returns two-cycle AHB ERROR responses.
- Sits between airi5c_top_asic and the SRAM macro in the FPGA top.

Parameters:
ADDR_WIDTH, 16, SRAM word-address width; sram_addr = haddr[ADDR_WIDTH+1:2]
REGION, 2'b10, required value of dmem_haddr[31:30] for a dmem access to reach SRAM
MAX_DSTREAK, 4, consecutive dmem issues allowed while imem is waiting before imem wins a conflict (range 1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
imem_haddr  in  32  instruction address
imem_hwrite  in  1  must be 0; a write is an error
imem_hsize  in  3  transfer size
imem_htrans  in  2  bit1=1 marks an active transfer
imem_hrdata  out  32  read data
imem_hready  out  1  transfer done / ready
imem_hresp  out  1  0=OKAY, 1=ERROR
dmem_haddr  in  32  data address
dmem_hwrite  in  1  write
dmem_hsize  in  3  transfer size
dmem_htrans  in  2  bit1=1 marks an active transfer
dmem_hwdata  in  32  write data (data phase)
dmem_hrdata  out  32  read data
dmem_hready  out  1  transfer done / ready
dmem_hresp  out  1  0=OKAY, 1=ERROR
sram_en  out  1  SRAM access this cycle
sram_addr  out  ADDR_WIDTH  word address
sram_we  out  4  byte write enables
sram_wdata  out  32  write data
sram_rdata  in  32  data for the previous cycle's address

Behaviour:
- Reset values: both ports IDLE, hready=1, hresp=0; sram_en=0, sram_we=0; starvation counter=0. sram_en and sram_we are forced to 0 in any cycle where reset=1.
- hburst, hprot, hmastlock are not used. hrdata of both ports = sram_rdata, pass-through; only meaningful in a read DONE cycle.
- Address-phase capture: at a rising edge where htrans[1]=1 and the port's own hready=1, latch haddr, hwrite and hsize. Captured transfer then goes to:
  - WAIT if legal;
  - ERR1 if illegal.
- Illegal transfers:
  - hsize>2;
  - hsize=1 with haddr[0]=1;
  - hsize=2 with haddr[1:0]!=0;
  - dmem_haddr[31:30]!=REGION;
  - imem_hwrite=1.
- Per-port FSM:
  - IDLE (hready=1, hresp=0): goes to WAIT or ERR1 on capture.
  - WAIT (hready=0, hresp=0): goes to DONE in the cycle after this port is issued to SRAM.
  - DONE (hready=1, hresp=0): captures the next transfer if one is present (to WAIT/ERR1), else goes to IDLE.
  - ERR1 (hready=0, hresp=1): always goes to ERR2.
  - ERR2 (hready=1, hresp=1): captures like DONE, else goes to IDLE.
- Issue rule: exactly one port in WAIT is issued per cycle, combinationally. The issue cycle drives:
  - sram_en=1;
  - sram_addr from the latched address;
  - for writes, sram_we and sram_wdata = dmem_hwdata (the master holds hwdata stable while hready=0).
- Byte enables: size0 = 4'b0001<<a[1:0]; size1 = 4'b0011<<{a[1],1'b0}; size2 = 4'b1111. Reads: sram_we=0.
- Latency, no contention: address phase, then 1 wait cycle (issue), then a DONE cycle with data. Per-port throughput is 1 transfer per 2 cycles. Both ports can interleave and keep SRAM 100% busy.
- Conflict (both in WAIT):
  - dmem issues, unless counter==MAX_DSTREAK, in which case imem issues.
  - counter increments on each dmem issue while imem is in WAIT, saturating at MAX_DSTREAK.
  - counter clears on imem issue, or when imem is not in WAIT.
- The losing port stays in WAIT with hready=0 and its latched request unchanged.
- Error transfers never touch SRAM.
- Reset mid-transfer: pending requests are dropped and no SRAM write occurs in the reset cycle. The next cycle is in reset state.

Test Plan:
- Reset then idle: both hready=1, hresp=0, sram_en=0, sram_we=0.
- dmem word write 0xDEADBEEF @0x80000010:
  - issue cycle: sram_addr=0x0004, sram_we=4'hF, sram_wdata=0xDEADBEEF;
  - DONE next cycle.
  - A following imem read @0x00000010 returns 0xDEADBEEF with 1 wait cycle.
- dmem byte write 0xAB @0x80000013: sram_we=4'b1000. Halfword write @0x80000012: sram_we=4'b1100.
- Simultaneous imem and dmem reads, dmem streaming continuously:
  - dmem wins 4 conflicts;
  - the 5th conflict goes to imem;
  - imem wait never exceeds 5 issue slots.
- Error cases, each giving an ERR1 then ERR2 sequence (hready 0 then 1, hresp=1) with sram_en=0 throughout:
  - dmem read @0x40000000;
  - dmem halfword @0x80000001;
  - imem write;
  - hsize=3.
- reset asserted during a dmem write's WAIT cycle: sram_we=0 that cycle; next cycle both ports IDLE with hready=1.
